// File: rtl/com_sync_fifo_mc_ctrl_pkg.sv
// Shared definitions for the multi-channel sync FIFO controller:
// channel-index type and range helper, width derivation, flag bit order.
package com_sync_fifo_mc_ctrl_pkg;

    // Wide enough to hold any channel request before range checking.
    typedef logic [31:0] ch_idx_t;

    // Bit order of the per-channel flag vector produced by com_fifo_ch_ptr.
    localparam int FLG_FULL   = 0;
    localparam int FLG_EMPTY  = 1;
    localparam int FLG_AFULL  = 2;
    localparam int FLG_AEMPTY = 3;
    localparam int FLG_NUM    = 4;

    // Level width: must represent 0..DEPTH inclusive.
    function automatic int calc_aw(int depth);
        return $clog2(depth + 1);
    endfunction

    // Channel select width, never below one bit.
    function automatic int calc_cw(int nch);
        return ($clog2(nch) < 1) ? 1 : $clog2(nch);
    endfunction

    // Flat memory address width across all channels.
    function automatic int calc_maw(int nch, int depth);
        return ($clog2(nch * depth) < 1) ? 1 : $clog2(nch * depth);
    endfunction

    // Pointer width: holds 0..DEPTH-1.
    function automatic int calc_pw(int depth);
        return ($clog2(depth) < 1) ? 1 : $clog2(depth);
    endfunction

    // True when a requested channel index addresses a real channel.
    function automatic logic ch_valid(ch_idx_t ch, int nch);
        return ch < ch_idx_t'(nch);
    endfunction

endpackage

// File: rtl/com_fifo_ch_ptr.sv
// One channel's write/read pointer pair with phase bits; derives
// full/empty/afull/aempty and the occupancy level.
module com_fifo_ch_ptr
    import com_sync_fifo_mc_ctrl_pkg::*;
#(
    parameter  int DEPTH  = 8,
    parameter  int AF_LVL = DEPTH - 1,
    parameter  int AE_LVL = 1,
    localparam int AW     = calc_aw(DEPTH),
    localparam int PW     = calc_pw(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               wr_inc,
    input  logic               rd_inc,
    output logic [PW-1:0]      wr_ptr,
    output logic [PW-1:0]      rd_ptr,
    output logic [FLG_NUM-1:0] flags,
    output logic [AW-1:0]      level
);

    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic wr_ph, rd_ph;

    // Pointer/phase update; a flush beats any increment in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            wr_ph  <= 1'b0;
            rd_ph  <= 1'b0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            wr_ph  <= 1'b0;
            rd_ph  <= 1'b0;
        end else begin
            if (wr_inc) begin
                if (wr_ptr == LAST) begin
                    wr_ptr <= '0;
                    wr_ph  <= ~wr_ph;
                end else begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
            end
            if (rd_inc) begin
                if (rd_ptr == LAST) begin
                    rd_ptr <= '0;
                    rd_ph  <= ~rd_ph;
                end else begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
            end
        end
    end

    // Level from pointers; modular arithmetic in AW bits stays exact
    // because the true result never exceeds DEPTH.
    always_comb begin
        level = '0;
        if (wr_ph == rd_ph)
            level = AW'(wr_ptr) - AW'(rd_ptr);
        else
            level = AW'(wr_ptr) + AW'(DEPTH) - AW'(rd_ptr);
    end

    // Status flags derived from pointer/phase comparison and level.
    always_comb begin
        flags             = '0;
        flags[FLG_FULL]   = (wr_ptr == rd_ptr) && (wr_ph != rd_ph);
        flags[FLG_EMPTY]  = (wr_ptr == rd_ptr) && (wr_ph == rd_ph);
        flags[FLG_AFULL]  = int'(level) >= AF_LVL;
        flags[FLG_AEMPTY] = int'(level) <= AE_LVL;
    end

endmodule

// File: rtl/com_sync_fifo_mc_ctrl.sv
// Multi-channel synchronous FIFO controller: NCH logical FIFOs of DEPTH
// entries sharing one flat memory. Produces flat write/read addresses,
// per-channel status and occupancy.
// Optional feature macro COM_FIFO_MC_ERR_STICKY_EN: sticky overflow and
// underflow flags; without it both flags are tied low.
module com_sync_fifo_mc_ctrl
    import com_sync_fifo_mc_ctrl_pkg::*;
#(
    parameter  int NCH    = 4,
    parameter  int DEPTH  = 8,
    parameter  int AF_LVL = DEPTH - 1,
    parameter  int AE_LVL = 1,
    localparam int AW     = calc_aw(DEPTH),
    localparam int CW     = calc_cw(NCH),
    localparam int MAW    = calc_maw(NCH, DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic [NCH-1:0]    ch_clear,
    input  logic              wr_en,
    input  logic [CW-1:0]     wr_ch,
    output logic [MAW-1:0]    wr_addr,
    input  logic              rd_en,
    input  logic [CW-1:0]     rd_ch,
    output logic [MAW-1:0]    rd_addr,
    output logic [NCH-1:0]    full,
    output logic [NCH-1:0]    empty,
    output logic [NCH-1:0]    afull,
    output logic [NCH-1:0]    aempty,
    output logic [NCH*AW-1:0] water_level,
    output logic              ovf_err,
    output logic              udf_err
);

    localparam int PW = calc_pw(DEPTH);

    if (DEPTH < 1) begin : g_bad_depth
        $error("com_sync_fifo_mc_ctrl: DEPTH must be >= 1");
    end
    if (NCH < 1) begin : g_bad_nch
        $error("com_sync_fifo_mc_ctrl: NCH must be >= 1");
    end
    if (AF_LVL > DEPTH) begin : g_bad_af
        $error("com_sync_fifo_mc_ctrl: AF_LVL must be <= DEPTH");
    end
    if (AE_LVL > DEPTH) begin : g_bad_ae
        $error("com_sync_fifo_mc_ctrl: AE_LVL must be <= DEPTH");
    end

    logic [NCH-1:0][PW-1:0]      wr_ptr, rd_ptr;
    logic [NCH-1:0][FLG_NUM-1:0] flags;
    logic [NCH-1:0][AW-1:0]      level;

    logic          wr_valid, rd_valid;
    logic          wr_sel_full, rd_sel_empty;
    logic [PW-1:0] wr_sel_ptr, rd_sel_ptr;
    logic          wr_ok, rd_ok;

    assign wr_valid = ch_valid(ch_idx_t'(wr_ch), NCH);
    assign rd_valid = ch_valid(ch_idx_t'(rd_ch), NCH);

    // Select the requested channel's pointer and flag; out-of-range
    // requests see pointer 0 and are rejected by the valid check.
    always_comb begin
        wr_sel_ptr   = '0;
        rd_sel_ptr   = '0;
        wr_sel_full  = 1'b0;
        rd_sel_empty = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            if (int'(wr_ch) == c) begin
                wr_sel_ptr  = wr_ptr[c];
                wr_sel_full = flags[c][FLG_FULL];
            end
            if (int'(rd_ch) == c) begin
                rd_sel_ptr   = rd_ptr[c];
                rd_sel_empty = flags[c][FLG_EMPTY];
            end
        end
    end

    // Accept decisions use pre-edge flags, so a same-channel write+read on
    // an empty (full) channel lets only the write (read) through.
    assign wr_ok = wr_en && wr_valid && !wr_sel_full;
    assign rd_ok = rd_en && rd_valid && !rd_sel_empty;

    assign wr_addr = MAW'(int'(wr_ch) * DEPTH + int'(wr_sel_ptr));
    assign rd_addr = MAW'(int'(rd_ch) * DEPTH + int'(rd_sel_ptr));

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        com_fifo_ch_ptr #(
            .DEPTH  (DEPTH),
            .AF_LVL (AF_LVL),
            .AE_LVL (AE_LVL)
        ) u_ptr (
            .clk    (clk),
            .rst_n  (rst_n),
            .flush  (clear | ch_clear[c]),
            .wr_inc (wr_ok && (int'(wr_ch) == c)),
            .rd_inc (rd_ok && (int'(rd_ch) == c)),
            .wr_ptr (wr_ptr[c]),
            .rd_ptr (rd_ptr[c]),
            .flags  (flags[c]),
            .level  (level[c])
        );

        assign full[c]                 = flags[c][FLG_FULL];
        assign empty[c]                = flags[c][FLG_EMPTY];
        assign afull[c]                = flags[c][FLG_AFULL];
        assign aempty[c]               = flags[c][FLG_AEMPTY];
        assign water_level[c*AW +: AW] = level[c];
    end

`ifdef COM_FIFO_MC_ERR_STICKY_EN
    logic ovf_q, udf_q;

    // Sticky error capture; only reset or a global clear wipes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else if (clear) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (wr_en && (!wr_valid || wr_sel_full)) ovf_q <= 1'b1;
            if (rd_en && (!rd_valid || rd_sel_empty)) udf_q <= 1'b1;
        end
    end

    assign ovf_err = ovf_q;
    assign udf_err = udf_q;
`else
    assign ovf_err = 1'b0;
    assign udf_err = 1'b0;
`endif

endmodule

// File: tb/tb_com_sync_fifo_mc_ctrl.sv
// Self-checking bench for com_sync_fifo_mc_ctrl: directed scenarios plus
// randomized traffic against an occupancy/position model of each channel.
module tb_com_sync_fifo_mc_ctrl;

    localparam int NCH = 4, DEPTH = 5, AF = 4, AE = 1;
    localparam int AW = 3, CW = 2, MAW = 5;
`ifdef COM_FIFO_MC_ERR_STICKY_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic              clear;
    logic [NCH-1:0]    ch_clear;
    logic              wr_en, rd_en;
    logic [CW-1:0]     wr_ch, rd_ch;
    logic [MAW-1:0]    wr_addr, rd_addr;
    logic [NCH-1:0]    full, empty, afull, aempty;
    logic [NCH*AW-1:0] water_level;
    logic              ovf_err, udf_err;

    com_sync_fifo_mc_ctrl #(.NCH(NCH), .DEPTH(DEPTH), .AF_LVL(AF), .AE_LVL(AE)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .ch_clear(ch_clear),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_addr(wr_addr),
        .rd_en(rd_en), .rd_ch(rd_ch), .rd_addr(rd_addr),
        .full(full), .empty(empty), .afull(afull), .aempty(aempty),
        .water_level(water_level), .ovf_err(ovf_err), .udf_err(udf_err)
    );

    // Second instance with NCH=3 so a 2-bit channel field can name a
    // non-existent channel (index 3).
    logic          s_clear, s_wr_en, s_rd_en;
    logic [2:0]    s_ch_clear;
    logic [1:0]    s_wr_ch, s_rd_ch;
    logic [3:0]    s_wr_addr, s_rd_addr;
    logic [2:0]    s_full, s_empty, s_afull, s_aempty;
    logic [8:0]    s_water_level;
    logic          s_ovf_err, s_udf_err;

    com_sync_fifo_mc_ctrl #(.NCH(3), .DEPTH(5), .AF_LVL(4), .AE_LVL(1)) dut_small (
        .clk(clk), .rst_n(rst_n), .clear(s_clear), .ch_clear(s_ch_clear),
        .wr_en(s_wr_en), .wr_ch(s_wr_ch), .wr_addr(s_wr_addr),
        .rd_en(s_rd_en), .rd_ch(s_rd_ch), .rd_addr(s_rd_addr),
        .full(s_full), .empty(s_empty), .afull(s_afull), .aempty(s_aempty),
        .water_level(s_water_level), .ovf_err(s_ovf_err), .udf_err(s_udf_err)
    );

    int n_pass = 0, n_tot = 0;
    bit chk_en = 1'b0;

    // Model: per-channel occupancy and the slot index the next write/read
    // lands on, plus the sticky error bits.
    int m_lvl[NCH], m_wp[NCH], m_rp[NCH];
    bit m_ovf, m_udf;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        else n_pass++;
    endtask

    function automatic void m_reset();
        for (int c = 0; c < NCH; c++) begin
            m_lvl[c] = 0; m_wp[c] = 0; m_rp[c] = 0;
        end
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endfunction

    // Advance the model by one clock edge using the inputs currently applied.
    function automatic void m_step();
        int  wc, rc;
        bit  wacc, racc;
        if (!rst_n || clear) begin
            m_reset();
            return;
        end
        wc = int'(wr_ch);
        rc = int'(rd_ch);
        wacc = wr_en && m_lvl[wc] < DEPTH && !ch_clear[wc];
        racc = rd_en && m_lvl[rc] > 0 && !ch_clear[rc];
        if (ERR_EN && wr_en && m_lvl[wc] == DEPTH) m_ovf = 1'b1;
        if (ERR_EN && rd_en && m_lvl[rc] == 0) m_udf = 1'b1;
        for (int c = 0; c < NCH; c++)
            if (ch_clear[c]) begin
                m_lvl[c] = 0; m_wp[c] = 0; m_rp[c] = 0;
            end
        if (wacc) begin
            m_lvl[wc]++;
            m_wp[wc] = (m_wp[wc] + 1) % DEPTH;
        end
        if (racc) begin
            m_lvl[rc]--;
            m_rp[rc] = (m_rp[rc] + 1) % DEPTH;
        end
    endfunction

    // Every negedge: all outputs of the main instance against the model.
    always @(negedge clk) begin : cmp
        logic [NCH-1:0]    e_full, e_empty, e_afull, e_aempty;
        logic [NCH*AW-1:0] e_wl;
        if (chk_en) begin
            for (int c = 0; c < NCH; c++) begin
                e_full[c]          = (m_lvl[c] == DEPTH);
                e_empty[c]         = (m_lvl[c] == 0);
                e_afull[c]         = (m_lvl[c] >= AF);
                e_aempty[c]        = (m_lvl[c] <= AE);
                e_wl[c*AW +: AW]   = AW'(m_lvl[c]);
            end
            chk("full", full, e_full);
            chk("empty", empty, e_empty);
            chk("afull", afull, e_afull);
            chk("aempty", aempty, e_aempty);
            chk("water_level", water_level, e_wl);
            chk("wr_addr", wr_addr, int'(wr_ch) * DEPTH + m_wp[int'(wr_ch)]);
            chk("rd_addr", rd_addr, int'(rd_ch) * DEPTH + m_rp[int'(rd_ch)]);
            chk("ovf_err", ovf_err, m_ovf);
            chk("udf_err", udf_err, m_udf);
        end
    end

    task automatic set_in(input bit we, input int wc, input bit re, input int rc,
                          input bit clr, input logic [NCH-1:0] chc);
        wr_en = we; wr_ch = CW'(wc); rd_en = re; rd_ch = CW'(rc);
        clear = clr; ch_clear = chc;
    endtask

    task automatic idle();
        set_in(0, 0, 0, 0, 0, '0);
    endtask

    task automatic tick();
        @(posedge clk);
        m_step();
        #1;
    endtask

    task automatic do_clear();
        set_in(0, 0, 0, 0, 1, '0);
        tick();
        idle();
    endtask

    int rd_seq[7] = '{0, 1, 2, 3, 4, 0, 1};

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        idle();
        s_clear = 0; s_ch_clear = '0; s_wr_en = 0; s_wr_ch = '0; s_rd_en = 0; s_rd_ch = '0;
        m_reset();
        #1 rst_n = 1'b0;
        #1;
        chk("rst_empty", empty, 4'hF);
        chk("rst_full", full, 4'h0);
        chk("rst_level", water_level, '0);
        chk("rst_aempty", aempty, 4'hF);
        chk("rst_afull", afull, 4'h0);
        chk("rst_ovf", ovf_err, 1'b0);
        chk("rst_udf", udf_err, 1'b0);
        tick(); tick();
        rst_n = 1'b1;
        chk_en = 1'b1;

        // Five writes to ch2 then one refused write.
        for (int i = 0; i < 5; i++) begin
            set_in(1, 2, 0, 0, 0, '0);
            #2 chk("wr_addr_ch2", wr_addr, 10 + i);
            tick();
            chk("afull2", afull[2], (i + 1) >= 4);
        end
        chk("full2", full[2], 1'b1);
        chk("level2_5", water_level[8:6], 3'd5);
        set_in(1, 2, 0, 0, 0, '0);
        #2 chk("wr_addr_ch2_wrap", wr_addr, 10);
        tick();
        chk("level2_hold", water_level[8:6], 3'd5);
        chk("ovf_after_full", ovf_err, ERR_EN);
        set_in(0, 2, 0, 0, 0, '0);
        #2 chk("wr_addr_ch2_nochg", wr_addr, 10);
        do_clear();
        chk("clear_ovf", ovf_err, 1'b0);

        // Interleaved write/read on ch0 across the wrap.
        for (int i = 0; i < 7; i++) begin
            set_in(1, 0, 0, 0, 0, '0);
            tick();
            set_in(0, 0, 1, 0, 0, '0);
            #2 chk("rd_addr_seq", rd_addr, rd_seq[i]);
            tick();
        end
        chk("empty0_end", empty[0], 1'b1);
        do_clear();

        // Same-cycle write+read on ch1: empty then full.
        set_in(1, 1, 1, 1, 0, '0);
        tick();
        chk("ch1_wr_only", water_level[5:3], 3'd1);
        chk("udf_empty_rd", udf_err, ERR_EN);
        for (int i = 0; i < 4; i++) begin
            set_in(1, 1, 0, 0, 0, '0);
            tick();
        end
        chk("full1", full[1], 1'b1);
        set_in(1, 1, 1, 1, 0, '0);
        tick();
        // Full is sampled before the edge: read drains one, write refused.
        chk("ch1_rd_only", water_level[5:3], 3'd4);
        chk("full1_drop", full[1], 1'b0);
        chk("ovf_full_wr", ovf_err, ERR_EN);
        set_in(0, 1, 0, 1, 0, '0);
        #2 chk("rd_addr_ch1", rd_addr, 6);
        chk("wr_addr_ch1", wr_addr, 5);
        do_clear();

        // ch_clear beats a same-cycle write and touches only its channel.
        for (int i = 0; i < 2; i++) begin set_in(1, 0, 0, 0, 0, '0); tick(); end
        for (int i = 0; i < 3; i++) begin set_in(1, 3, 0, 0, 0, '0); tick(); end
        chk("level3_pre", water_level[11:9], 3'd3);
        set_in(1, 3, 0, 0, 0, 4'b1000);
        tick();
        chk("level3_flushed", water_level[11:9], 3'd0);
        chk("level0_kept", water_level[2:0], 3'd2);
        set_in(0, 3, 0, 0, 0, '0);
        #2 chk("wr_addr_ch3_flushed", wr_addr, 15);
        do_clear();

        // Asynchronous reset mid-burst with every channel at level 2.
        for (int c = 0; c < NCH; c++)
            for (int i = 0; i < 2; i++) begin set_in(1, c, 0, 0, 0, '0); tick(); end
        chk("all_lvl2", water_level, {3'd2, 3'd2, 3'd2, 3'd2});
        set_in(1, 0, 1, 1, 0, '0);
        tick();
        set_in(1, 1, 1, 2, 0, '0);
        #2 rst_n = 1'b0;
        m_reset();
        #1;
        chk("arst_empty", empty, 4'hF);
        chk("arst_full", full, 4'h0);
        chk("arst_level", water_level, '0);
        chk("arst_aempty", aempty, 4'hF);
        chk("arst_afull", afull, 4'h0);
        chk("arst_ovf", ovf_err, 1'b0);
        chk("arst_udf", udf_err, 1'b0);
        tick();
        idle();
        rst_n = 1'b1;
        for (int c = 0; c < NCH; c++) begin
            set_in(1, c, 0, 0, 0, '0);
            #2 chk("wr_addr_post_rst", wr_addr, c * 5);
            tick();
        end
        do_clear();

        // Randomized traffic, occasional flushes.
        for (int n = 0; n < 500; n++) begin
            logic [NCH-1:0] chc;
            for (int c = 0; c < NCH; c++) chc[c] = ($urandom_range(0, 39) == 0);
            set_in($urandom_range(0, 9) < 6, $urandom_range(0, NCH - 1),
                   $urandom_range(0, 9) < 5, $urandom_range(0, NCH - 1),
                   $urandom_range(0, 99) == 0, chc);
            tick();
        end
        idle();
        tick();

        // Out-of-range channel on the NCH=3 instance.
        s_wr_en = 1; s_wr_ch = 2'd2;
        tick();
        s_wr_en = 0;
        chk("s_lvl_pre", s_water_level, {3'd1, 3'd0, 3'd0});
        chk("s_ovf_pre", s_ovf_err, 1'b0);
        s_wr_en = 1; s_wr_ch = 2'd3; s_rd_en = 1; s_rd_ch = 2'd3;
        tick();
        s_wr_en = 0; s_rd_en = 0;
        chk("s_lvl_oor", s_water_level, {3'd1, 3'd0, 3'd0});
        chk("s_empty_oor", s_empty, 3'b011);
        chk("s_ovf_oor", s_ovf_err, ERR_EN);
        chk("s_udf_oor", s_udf_err, ERR_EN);
        s_ch_clear = 3'b111;
        tick();
        s_ch_clear = '0;
        chk("s_ovf_chclr_keeps", s_ovf_err, ERR_EN);
        chk("s_lvl_chclr", s_water_level, '0);
        s_clear = 1;
        tick();
        s_clear = 0;
        chk("s_ovf_clear", s_ovf_err, 1'b0);
        chk("s_udf_clear", s_udf_err, 1'b0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
